// File: rtl/pll_seq_pkg.sv
// -----------------------------------------------------------------------------
// pll_seq_pkg
// Shared types and constants for the PLL reset/lock sequencer.
//   state_t    : FSM state encoding (also exported on the 'state' port).
//   SAT_W      : width of the saturating event counters (retry_cnt, loss_cnt).
//   sat_inc    : saturating increment for SAT_W-wide counters.
//   min_cnt_w  : smallest cycle-counter width that can hold every terminal
//                count (RST_CYCLES-1, STABLE_CYCLES-1, TIMEOUT_CYCLES-1).
// -----------------------------------------------------------------------------
package pll_seq_pkg;

   typedef enum logic [1:0] {
      PLLRST    = 2'b00,
      WAIT_LOCK = 2'b01,
      STABLE    = 2'b10,
      RUN       = 2'b11
   } state_t;

   localparam int SAT_W = 8;

   function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] v);
      return (v == '1) ? v : v + SAT_W'(1);
   endfunction

   function automatic int min_cnt_w(input int rst_cycles,
                                    input int stable_cycles,
                                    input int timeout_cycles);
      int m;
      m = rst_cycles;
      if (stable_cycles > m)  m = stable_cycles;
      if (timeout_cycles > m) m = timeout_cycles;
      return (m < 2) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/pll_reset_seq_sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Generic two-flop synchroniser for signals arriving asynchronously to clk.
// Output follows the input with two clk edges of latency.
//   clk : destination clock
//   rst : synchronous, active-high reset; clears both stages
//   d   : asynchronous input (W bits, each bit synchronised independently)
//   q   : synchronised output
// -----------------------------------------------------------------------------
module sync_2ff #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] meta;

   // NOTE: flops are written with non-blocking assignments so both stages
   // sample their inputs before either updates; blocking here would collapse
   // the two stages into one.
   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/pll_reset_seq.sv
// -----------------------------------------------------------------------------
// pll_reset_seq
// Sequences the system PLL: pulses its reset, waits for lock (retrying on
// timeout), requires lock to stay stable before releasing the core reset,
// and restarts the whole sequence on any lock loss while running.
//
// Ports:
//   refclk     : reference clock, the only clock of the block
//   rst        : synchronous, active-high reset (highest priority)
//   pll_locked : PLL lock indicator, asynchronous to refclk
//   pll_rst    : PLL reset, high only in PLLRST
//   sys_reset  : core reset, low only in RUN
//   ready      : high only in RUN
//   state      : current FSM encoding (PLLRST=00 WAIT_LOCK=01 STABLE=10 RUN=11)
//   retry_cnt  : number of lock timeouts, saturating at 255
//   loss_cnt   : number of RUN lock losses, saturating at 255
//
// Build option:
//   PLL_SEQ_LOSSCNT_EN : when defined, loss_cnt counts RUN->PLLRST
//                        transitions; when undefined, loss_cnt is tied to 0.
// -----------------------------------------------------------------------------
module pll_reset_seq
   import pll_seq_pkg::*;
#(
   parameter int RST_CYCLES     = 16,
   parameter int STABLE_CYCLES  = 1024,
   parameter int TIMEOUT_CYCLES = 1048576,
   parameter int CNT_W          = 21
) (
   input  logic             refclk,
   input  logic             rst,
   input  logic             pll_locked,
   output logic             pll_rst,
   output logic             sys_reset,
   output logic             ready,
   output logic [1:0]       state,
   output logic [SAT_W-1:0] retry_cnt,
   output logic [SAT_W-1:0] loss_cnt
);

   localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic             locked_s;
   state_t           state_q, state_nxt;
   logic [CNT_W-1:0] cnt_q, cnt_nxt;
   logic [SAT_W-1:0] retry_nxt;

   sync_2ff #(.W(1)) u_lock_sync (
      .clk (refclk),
      .rst (rst),
      .d   (pll_locked),
      .q   (locked_s)
   );

   // Every count terminates on an equality compare, so cnt never wraps.
   always_comb begin
      // NOTE: defaults first so every path assigns every output; a missing
      // assignment in combinational logic would infer a latch.
      state_nxt = state_q;
      cnt_nxt   = cnt_q;
      retry_nxt = retry_cnt;
      case (state_q)
         PLLRST: begin
            if (cnt_q == RST_LAST) begin
               state_nxt = WAIT_LOCK;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt_q + CNT_W'(1);
            end
         end
         WAIT_LOCK: begin
            // Lock is tested first so it wins over a coincident timeout.
            if (locked_s) begin
               state_nxt = STABLE;
               cnt_nxt   = '0;
            end else if (cnt_q == TIMEOUT_LAST) begin
               state_nxt = PLLRST;
               cnt_nxt   = '0;
               retry_nxt = sat_inc(retry_cnt);
            end else begin
               cnt_nxt = cnt_q + CNT_W'(1);
            end
         end
         STABLE: begin
            // A drop on the last stable cycle still falls back to WAIT_LOCK.
            if (!locked_s) begin
               state_nxt = WAIT_LOCK;
               cnt_nxt   = '0;
            end else if (cnt_q == STABLE_LAST) begin
               state_nxt = RUN;
            end else begin
               cnt_nxt = cnt_q + CNT_W'(1);
            end
         end
         RUN: begin
            if (!locked_s) begin
               state_nxt = PLLRST;
               cnt_nxt   = '0;
            end
         end
         default: begin
            state_nxt = PLLRST;
            cnt_nxt   = '0;
         end
      endcase
   end

   // Outputs are decoded from the next state and registered, so they always
   // equal a Moore decode of state_q without a combinational output path.
   always_ff @(posedge refclk) begin
      if (rst) begin
         state_q   <= PLLRST;
         cnt_q     <= '0;
         retry_cnt <= '0;
         pll_rst   <= 1'b1;
         sys_reset <= 1'b1;
         ready     <= 1'b0;
      end else begin
         state_q   <= state_nxt;
         cnt_q     <= cnt_nxt;
         retry_cnt <= retry_nxt;
         pll_rst   <= (state_nxt == PLLRST);
         sys_reset <= (state_nxt != RUN);
         ready     <= (state_nxt == RUN);
      end
   end

   assign state = state_q;

`ifdef PLL_SEQ_LOSSCNT_EN
   logic loss_evt;

   assign loss_evt = (state_q == RUN) && !locked_s;

   always_ff @(posedge refclk) begin
      if (rst) begin
         loss_cnt <= '0;
      end else if (loss_evt) begin
         loss_cnt <= sat_inc(loss_cnt);
      end
   end
`else
   assign loss_cnt = '0;
`endif

endmodule

// File: doc/pll_reset_seq.md
Name: pll_reset_seq

Overview:
- Sequences reset and lock for the system PLL (refclk 50 MHz in; 24 / 21.47 / 4 MHz out).
- Drives the PLL reset pulse and watches the PLL lock output.
- Releases the core reset only after lock has been continuously stable.
- Retries the PLL after a lock timeout; reasserts core reset on any lock loss.

Parameters:
- RST_CYCLES, 16: width of the pll_rst pulse in refclk cycles (>=1).
- STABLE_CYCLES, 1024: cycles locked must stay high before core reset is released (>=1).
- TIMEOUT_CYCLES, 1048576: maximum cycles to wait for lock before retrying (>=2).
- CNT_W, 21: shared counter width; >= clog2 of the largest of the three counts above.

Ports:
- refclk  in  1  PLL reference clock; the block's only clock.
- rst  in  1  synchronous, active-high reset.
- pll_locked  in  1  PLL lock, asynchronous to refclk.
- pll_rst  out  1  reset to the PLL, active high.
- sys_reset  out  1  core reset, active high.
- ready  out  1  high only in RUN.
- state  out  2  current FSM encoding.
- retry_cnt  out  8  lock-timeout count, saturating.
- loss_cnt  out  8  lock-loss count, saturating (optional feature).

Behaviour:
- One clock: refclk. Reset is synchronous and active-high on rst; rst has priority over every other event.
- Values while rst is high:
  - state=PLLRST, cnt=0, retry_cnt=0, loss_cnt=0, synchroniser flops=0.
  - pll_rst=1, sys_reset=1, ready=0.
- pll_locked passes through a 2-flop synchroniser to give locked_s (2-cycle latency).
- All outputs are registered Moore decodes of state:
  - pll_rst=1 only in PLLRST.
  - sys_reset=0 and ready=1 only in RUN.
- FSM encodings: PLLRST=00, WAIT_LOCK=01, STABLE=10, RUN=11.
- PLLRST: cnt increments each cycle; at cnt==RST_CYCLES-1, go to WAIT_LOCK with cnt=0. pll_rst is high exactly RST_CYCLES cycles.
- WAIT_LOCK:
  - locked_s=1: go to STABLE, cnt=0.
  - Else at cnt==TIMEOUT_CYCLES-1: go to PLLRST, cnt=0, retry_cnt+1 (saturates at 255).
  - Lock and timeout in the same cycle: lock wins.
- STABLE:
  - locked_s=0: go to WAIT_LOCK, cnt=0 (timeout window restarts).
  - Else at cnt==STABLE_CYCLES-1: go to RUN.
  - Lock drop on the final STABLE cycle goes to WAIT_LOCK, not RUN.
- RUN: cnt held. locked_s=0: go to PLLRST, cnt=0. sys_reset reasserts on the next edge, and the full sequence reruns.
- Timing: with pll_locked held high, sys_reset falls exactly STABLE_CYCLES+3 refclk edges after pll_locked rises.
- Counter arithmetic is unsigned CNT_W bits and never wraps; every compare is an equality that terminates the count.

Optional Feature:
- Macro PLL_SEQ_LOSSCNT_EN, defined: loss_cnt increments on every RUN->PLLRST transition, saturates at 255, clears on rst.
- Not defined: loss_cnt is tied to 0 and no counter logic is generated. The port list is identical either way.

Decomposition:
- Package pll_seq_pkg:
  - state enum with the 2-bit encodings above.
  - Saturating-counter width constant (8).
  - Helper function computing the minimum CNT_W.
- Sub-module sync_2ff: generic 2-flop synchroniser with synchronous active-high reset, instantiated for pll_locked.

Test Plan (RST_CYCLES=4, STABLE_CYCLES=8, TIMEOUT_CYCLES=32):
- Release rst; raise pll_locked 10 cycles later and hold -> pll_rst high exactly 4 cycles; sys_reset falls exactly 11 edges after the pll_locked rise; ready=1; state=11.
- pll_locked held 0 -> pll_rst re-pulses every 36 cycles; retry_cnt reads 1, 2, 3 after each timeout; sys_reset stays 1.
- pll_locked high 5 cycles, low 3, then high -> state returns 01 after the first drop; sys_reset stays 1; release occurs 11 edges after the second rise.
- In RUN, drop pll_locked for 1 cycle -> sys_reset=1 and pll_rst=1 three edges later; pll_rst lasts 4 cycles; recovery follows. With PLL_SEQ_LOSSCNT_EN loss_cnt=1, without it loss_cnt=0.
- Assert rst mid-STABLE (cnt=5) -> next edge: state=00, pll_rst=1, sys_reset=1, ready=0, retry_cnt=0.
- Force 300 consecutive timeouts -> retry_cnt saturates at 255 and holds.
